vdp_super_vram_prefetch: RTL and testbench

Sequential VRAM read prefetcher for the super-resolution display path. It streams 32-bit words from a linear VRAM address into a small first-word-fall-through FIFO. The pixel stage pops one word per fetch slot instead of depending on fixed-latency VRAM access. It sits between the SDRAM read port and the super-res pixel generator, whose `vrm_32` input it feeds.

---
 rtl/vdp_super_vram_prefetch.sv | 138 +++++++++++++
 tb/tb_vdp_super_vram_prefetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_vram_prefetch.sv
// Sequential VRAM read prefetcher: streams 32-bit words from a linear address
// into a small first-word-fall-through FIFO feeding the super-res pixel stage.
module vdp_super_vram_prefetch #(
  parameter int DEPTH     = 4,
  parameter int ADDR_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [16:0] start_addr,
  input  logic        pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        underrun,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [16:0] next_addr_reg;
  logic        underrun_reg;

  logic flush;
  logic inflight;
  logic credit;
  logic push;
  logic do_pop;

  // A low enable behaves as a continuous flush, which also keeps the FSM in IDLE.
  assign flush    = frame_start | ~enable;
  assign inflight = (state_reg == WAIT) || (state_reg == DRAIN);
  assign credit   = (count_reg + CW'(inflight)) < CW'(DEPTH);
  assign push     = (state_reg == WAIT) && mem_data_valid && !flush;
  assign do_pop   = pop && (count_reg != '0) && !flush;

  assign rd_valid = (count_reg != '0);
  assign rd_data  = rd_valid ? fifo_mem[rd_ptr_reg] : 32'h0;
  assign underrun = underrun_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      underrun_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      if (frame_start) begin
        underrun_reg <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!push && do_pop) begin
        count_reg <= count_reg - CW'(1);
      end
      if (pop && (count_reg == '0)) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      next_addr_reg <= '0;
    end else begin
      if (frame_start) begin
        next_addr_reg <= start_addr;
      end
      case (state_reg)
        IDLE: begin
          if (!flush && credit) begin
            state_reg <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= next_addr_reg;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            state_reg <= flush ? DRAIN : WAIT;
            if (!frame_start) begin
              next_addr_reg <= next_addr_reg + 17'(ADDR_STEP);
            end
          end else if (flush) begin
            mem_req   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        WAIT: begin
          // Data arriving in the flush cycle is simply dropped; DRAIN would never see it.
          if (mem_data_valid) begin
            state_reg <= IDLE;
          end else if (flush) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_data_valid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_prefetch.sv
// Randomized bench for vdp_super_vram_prefetch: memory responder plus a
// queue-based FIFO/address model checked every cycle on the falling edge.
module tb_vdp_super_vram_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [16:0] start_addr = '0;
  logic        pop = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        underrun;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;

  vdp_super_vram_prefetch #(.DEPTH(DEPTH), .ADDR_STEP(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .start_addr(start_addr), .pop(pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .underrun(underrun), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // stimulus knobs
  bit          en_want = 1'b0;
  bit          fs_req = 1'b0;
  logic [16:0] start_want = '0;
  int          pop_mode = 0;
  bit          stall = 1'b0;
  int          ack_max = 0;
  int          ack_wait = 0;
  int          lat_min = 2;
  int          lat_max = 2;
  int          dv_cnt = 0;
  logic [16:0] dv_addr = '0;

  // reference model
  logic [31:0] q[$];
  logic [16:0] exp_addr = '0;
  bit          m_inflight = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_underrun = 1'b0;
  logic [16:0] ack_log[$];
  int          ack_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit flush;
    @(negedge clk);
    cyc++;
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("rd_data", rd_data, (q.size() != 0) ? q[0] : 32'h0);
    check("underrun", 32'(underrun), 32'(m_underrun));
    if (mem_req) begin
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("credit", 32'(q.size() < DEPTH), 32'd1);
    end

    enable      = en_want;
    frame_start = fs_req;
    fs_req      = 1'b0;
    start_addr  = start_want;
    case (pop_mode)
      0:       pop = 1'b0;
      1:       pop = (cyc % 4 == 0);
      2:       pop = 1'b1;
      default: pop = ($urandom_range(0, 3) == 0);
    endcase

    mem_ack        = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = $urandom;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        mem_data_valid = 1'b1;
        mem_data       = {15'h0, dv_addr};
      end
    end
    if (mem_req && !stall) begin
      if (ack_wait == 0) begin
        mem_ack  = 1'b1;
        ack_wait = $urandom_range(0, ack_max);
        dv_cnt   = $urandom_range(lat_min, lat_max);
        dv_addr  = mem_addr;
      end else begin
        ack_wait--;
      end
    end

    // model what the coming rising edge does
    flush = frame_start || !enable || reset;
    if (pop && !flush) begin
      if (q.size() != 0) void'(q.pop_front());
      else m_underrun = 1'b1;
    end
    if (mem_data_valid) begin
      if (!m_discard && !flush) q.push_back(mem_data);
      m_inflight = 1'b0;
    end
    if (mem_ack) begin
      $display("req %0d addr=%05h cycle=%0d", ack_cnt, mem_addr, cyc);
      ack_log.push_back(mem_addr);
      ack_cnt++;
      exp_addr   = exp_addr + 17'd2;
      m_inflight = 1'b1;
      m_discard  = flush;
    end
    if (flush && m_inflight) m_discard = 1'b1;
    if (flush) begin
      q.delete();
      if (frame_start) begin
        exp_addr   = start_addr;
        m_underrun = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input string tag);
    int g = 0;
    while (!mem_req && g < 60) begin
      step();
      g++;
    end
    check(tag, 32'(g < 60), 32'd1);
  endtask

  initial begin
    int g;
    int a0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // fill from 0x00100
    en_want = 1'b1; ack_max = 0; lat_min = 2; lat_max = 2;
    start_want = 17'h00100; fs_req = 1'b1;
    step();
    step();
    check("req_f1", 32'(mem_req), 32'd0);
    check("flush_valid_f1", 32'(rd_valid), 32'd0);
    step();
    check("req_f2", 32'(mem_req), 32'd1);
    repeat (40) step();
    check("fill_count", 32'(q.size()), DEPTH);
    check("fill_head", rd_data, 32'h0000_0100);
    check("fill_stop", 32'(mem_req), 32'd0);
    check("fill_addr3", 32'(ack_log[3]), 32'h00106);

    // steady state: pop every 4th cycle
    pop_mode = 1;
    repeat (800) step();
    check("steady_underrun", 32'(underrun), 32'd0);

    // underrun after fill with memory stalled
    pop_mode = 0;
    repeat (40) step();
    stall = 1'b1;
    repeat (10) step();
    pop_mode = 2;
    repeat (5) step();
    pop_mode = 0;
    step();
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_data", rd_data, 32'd0);
    start_want = 17'h00040; fs_req = 1'b1;
    step();
    stall = 1'b0;
    step();
    check("underrun_clear", 32'(underrun), 32'd0);

    // flush while a read is in flight
    g = 0;
    while (!m_inflight && g < 60) begin step(); g++; end
    check("wait_inflight", 32'(g < 60), 32'd1);
    start_want = 17'h02000; fs_req = 1'b1;
    step();
    step();
    check("midflush_valid", 32'(rd_valid), 32'd0);
    a0 = ack_cnt; g = 0;
    while (ack_cnt == a0 && g < 60) begin step(); g++; end
    check("midflush_addr", 32'(ack_log[ack_log.size()-1]), 32'h02000);

    // wrap with a stalled ack
    stall = 1'b1;
    start_want = 17'h1FFFC; fs_req = 1'b1;
    step();
    wait_req("wrap_req_seen");
    repeat (10) begin
      step();
      check("stall_addr", 32'(mem_addr), 32'h1FFFC);
    end
    ack_log.delete();
    stall = 1'b0;
    repeat (30) step();
    check("wrap_a0", 32'(ack_log[0]), 32'h1FFFC);
    check("wrap_a1", 32'(ack_log[1]), 32'h1FFFE);
    check("wrap_a2", 32'(ack_log[2]), 32'h00000);

    // enable drop while a request waits for ack
    start_want = 17'h00800; fs_req = 1'b1; stall = 1'b1;
    step();
    wait_req("drop_req_seen");
    en_want = 1'b0;
    step();
    step();
    check("drop_req", 32'(mem_req), 32'd0);
    stall = 1'b0; pop_mode = 3;
    repeat (20) begin
      step();
      check("drop_no_req", 32'(mem_req), 32'd0);
      check("drop_no_push", 32'(rd_valid), 32'd0);
    end
    en_want = 1'b1; pop_mode = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        ack_max = $urandom_range(0, 3);
        lat_min = $urandom_range(1, 2);
        lat_max = lat_min + $urandom_range(0, 2);
        pop_mode = $urandom_range(0, 3);
      end
      if (en_want && $urandom_range(0, 299) == 0) en_want = 1'b0;
      else if (!en_want && $urandom_range(0, 7) == 0) en_want = 1'b1;
      if (!stall && $urandom_range(0, 49) == 0) stall = 1'b1;
      else if (stall && $urandom_range(0, 4) == 0) stall = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        fs_req = 1'b1;
        start_want = ($urandom_range(0, 1) == 0) ? 17'($urandom) : 17'h1FFF0 + 17'($urandom_range(0, 15));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
